// File: rtl/oled_pkg.sv
// Shared constants, init command ROM and FSM encoding for the SSD1331 Pmod OLED driver.
package oled_pkg;

  localparam int unsigned OLED_W    = 96;
  localparam int unsigned OLED_H    = 64;
  localparam int unsigned OLED_NPIX = OLED_W * OLED_H;

  localparam int unsigned INIT_LEN       = 37;
  localparam logic [7:0]  CMD_DISPLAY_ON = 8'hAF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_PWR,
    S_CMD,
    S_VCC,
    S_ON,
    S_PIX
  } oled_state_e;

  function automatic logic [7:0] init_byte(input logic [5:0] idx);
    logic [7:0] b;
    case (idx)
      6'd0:  b = 8'hAE;
      6'd1:  b = 8'hA0;
      6'd2:  b = 8'h72;
      6'd3:  b = 8'hA1;
      6'd4:  b = 8'h00;
      6'd5:  b = 8'hA2;
      6'd6:  b = 8'h00;
      6'd7:  b = 8'hA4;
      6'd8:  b = 8'hA8;
      6'd9:  b = 8'h3F;
      6'd10: b = 8'hAD;
      6'd11: b = 8'h8E;
      6'd12: b = 8'hB0;
      6'd13: b = 8'h0B;
      6'd14: b = 8'hB1;
      6'd15: b = 8'h31;
      6'd16: b = 8'hB3;
      6'd17: b = 8'hF0;
      6'd18: b = 8'h8A;
      6'd19: b = 8'h64;
      6'd20: b = 8'h8B;
      6'd21: b = 8'h78;
      6'd22: b = 8'h8C;
      6'd23: b = 8'h64;
      6'd24: b = 8'hBB;
      6'd25: b = 8'h3A;
      6'd26: b = 8'hBE;
      6'd27: b = 8'h3E;
      6'd28: b = 8'h87;
      6'd29: b = 8'h06;
      6'd30: b = 8'h81;
      6'd31: b = 8'h91;
      6'd32: b = 8'h82;
      6'd33: b = 8'h50;
      6'd34: b = 8'h83;
      6'd35: b = 8'h7D;
      6'd36: b = 8'h2E;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/oled_spi_shifter.sv
// SPI serialiser: sclk tick generator plus a 16-bit MSB-first shift register.
// sdin moves on sclk falling; back-to-back words are possible by loading while load_req is high.
module oled_spi_shifter #(
  parameter int unsigned CLK_DIV = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        wide,
  input  logic [15:0] data,
  output logic        sclk,
  output logic        sdin,
  output logic        busy,
  output logic        load_req,
  output logic        last_bit
);

  localparam int unsigned DivW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;

  logic [DivW-1:0] div_q;
  logic [15:0]     shift_q;
  logic [3:0]      bits_q;
  logic            sclk_q;
  logic            busy_q;
  logic            tick;

  assign tick = (div_q == DivW'(CLK_DIV));

  // Both fire in the final cycle of a high half-period, i.e. just before the next falling edge.
  assign load_req = busy_q && sclk_q && tick && (bits_q == 4'd0);
  assign last_bit = busy_q && sclk_q && tick && (bits_q == 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      shift_q <= '0;
      bits_q  <= '0;
      sclk_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else if (load) begin
      shift_q <= wide ? data : {data[7:0], 8'h00};
      bits_q  <= wide ? 4'd15 : 4'd7;
      sclk_q  <= 1'b0;
      div_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      if (tick) begin
        div_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
        end else if (bits_q == 4'd0) begin
          busy_q <= 1'b0;
        end else begin
          shift_q <= {shift_q[14:0], 1'b0};
          bits_q  <= bits_q - 4'd1;
          sclk_q  <= 1'b0;
        end
      end else begin
        div_q <= div_q + DivW'(1);
      end
    end
  end

  assign sclk = sclk_q;
  assign sdin = shift_q[15];
  assign busy = busy_q;

endmodule

// File: rtl/oled_spi_driver.sv
// SSD1331 Pmod OLED driver: power-up sequencing, init command stream and continuous
// RGB565 pixel streaming with published scan coordinates.
module oled_spi_driver
  import oled_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 7,
  parameter int unsigned RST_CYCLES = 300,
  parameter int unsigned PWR_CYCLES = 300,
  parameter int unsigned VCC_CYCLES = 10000,
  parameter int unsigned PANEL_ROWS = OLED_H
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic [6:0]  x,
  output logic [6:0]  y,
  output logic        sample_pixel,
  output logic        frame_begin,
  output logic        ready,
  output logic        cs,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn,
  output logic        resn,
  output logic        vccen,
  output logic        pmoden
);

  localparam int unsigned MaxRp   = (RST_CYCLES > PWR_CYCLES) ? RST_CYCLES : PWR_CYCLES;
  localparam int unsigned MaxWait = (MaxRp > VCC_CYCLES) ? MaxRp : VCC_CYCLES;
  localparam int unsigned CntW    = $clog2(MaxWait + 1);
  localparam int unsigned LastIdx = OLED_W * PANEL_ROWS - 1;

  oled_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [5:0]      cmd_idx_q;
  logic            cs_q;
  logic [12:0]     idx_q;
  logic [6:0]      x_q, y_q;

  logic        sh_load, sh_wide, sh_busy, sh_load_req, sh_last_bit;
  logic [15:0] sh_data;

  oled_spi_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (sh_load),
    .wide    (sh_wide),
    .data    (sh_data),
    .sclk    (sclk),
    .sdin    (sdin),
    .busy    (sh_busy),
    .load_req(sh_load_req),
    .last_bit(sh_last_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_RST;
      S_RST:  if (cnt_q == CntW'(RST_CYCLES - 1)) state_d = S_PWR;
      S_PWR:  if (cnt_q == CntW'(PWR_CYCLES - 1)) state_d = S_CMD;
      S_CMD:  if (!sh_busy && cmd_idx_q == 6'(INIT_LEN)) state_d = S_VCC;
      S_VCC:  if (cnt_q == CntW'(VCC_CYCLES - 1)) state_d = S_ON;
      S_ON:   if (sh_load_req) state_d = S_PIX;
      S_PIX:  state_d = S_PIX;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sh_load      = 1'b0;
    sh_wide      = 1'b0;
    sh_data      = '0;
    sample_pixel = 1'b0;
    frame_begin  = 1'b0;
    pmoden       = (state_q != S_IDLE);
    resn         = state_q inside {S_PWR, S_CMD, S_VCC, S_ON, S_PIX};
    vccen        = state_q inside {S_VCC, S_ON, S_PIX};
    d_cn         = (state_q == S_PIX);
    ready        = (state_q == S_PIX);
    unique case (state_q)
      S_CMD: begin
        if ((!sh_busy || sh_load_req) && cmd_idx_q < 6'(INIT_LEN)) begin
          sh_load = 1'b1;
          sh_data = {8'h00, init_byte(cmd_idx_q)};
        end
      end
      S_ON: begin
        if (!sh_busy) begin
          sh_load = 1'b1;
          sh_data = {8'h00, CMD_DISPLAY_ON};
        end else if (sh_load_req) begin
          // First pixel is chained straight onto the display-on byte.
          sh_load      = 1'b1;
          sh_wide      = 1'b1;
          sh_data      = pixel_data;
          sample_pixel = 1'b1;
          frame_begin  = (idx_q == '0);
        end
      end
      S_PIX: begin
        if (sh_load_req) begin
          sh_load      = 1'b1;
          sh_wide      = 1'b1;
          sh_data      = pixel_data;
          sample_pixel = 1'b1;
          frame_begin  = (idx_q == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q inside {S_RST, S_PWR, S_VCC}) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_idx_q <= '0;
      cs_q      <= 1'b1;
    end else begin
      if (state_q == S_CMD && sh_load) cmd_idx_q <= cmd_idx_q + 6'd1;
      if (sh_load) cs_q <= 1'b0;
    end
  end

  // Coordinates move at the start of the current pixel's last bit, well ahead of the next capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (state_q == S_PIX && sh_last_bit) begin
      if (x_q == 7'(OLED_W - 1)) begin
        x_q <= '0;
        y_q <= (y_q == 7'(PANEL_ROWS - 1)) ? 7'd0 : y_q + 7'd1;
      end else begin
        x_q <= x_q + 7'd1;
      end
      idx_q <= (idx_q == 13'(LastIdx)) ? 13'd0 : idx_q + 13'd1;
    end
  end

  assign cs          = cs_q;
  assign pixel_index = idx_q;
  assign x           = x_q;
  assign y           = y_q;

endmodule

// File: tb/tb_oled_spi_driver.sv
// Directed bench for oled_spi_driver: power-up, init stream, display-on, pixel stream,
// frame wrap and asynchronous reset mid-pixel, with a 4-row panel to keep frames short.
module tb_oled_spi_driver;

  localparam int NPIX = 96 * 4;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pixel_data;
  logic [12:0] pixel_index;
  logic [6:0]  x, y;
  logic        sample_pixel, frame_begin, ready, cs, sclk, sdin, d_cn, resn, vccen, pmoden;

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign pixel_data = {x, 2'b00, y};

  oled_spi_driver #(
    .CLK_DIV   (1),
    .RST_CYCLES(20),
    .PWR_CYCLES(20),
    .VCC_CYCLES(20),
    .PANEL_ROWS(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_data  (pixel_data),
    .pixel_index (pixel_index),
    .x           (x),
    .y           (y),
    .sample_pixel(sample_pixel),
    .frame_begin (frame_begin),
    .ready       (ready),
    .cs          (cs),
    .sclk        (sclk),
    .sdin        (sdin),
    .d_cn        (d_cn),
    .resn        (resn),
    .vccen       (vccen),
    .pmoden      (pmoden)
  );

  // SPI decoder: panel-side view of the bus
  logic [15:0] acc = '0;
  int          bitcnt = 0;
  logic [7:0]  cmd_q[$];
  logic [15:0] pix_q[$];

  always @(posedge sclk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      bitcnt <= 0;
    end else begin
      acc    <= {acc[14:0], sdin};
      bitcnt <= bitcnt + 1;
      if (!d_cn && bitcnt == 7) begin
        cmd_q.push_back({acc[6:0], sdin});
        bitcnt <= 0;
      end else if (d_cn && bitcnt == 15) begin
        pix_q.push_back({acc[14:0], sdin});
        bitcnt <= 0;
      end
    end
  end

  // Pixel handshake monitor
  int          held = 0;
  int          held_now;
  logic [13:0] prev_xy = '0;
  logic [13:0] last_xy = '0;
  logic [13:0] wrap_xy = '1;
  int samp_cnt = 0, fb_cnt = 0, fb_err = 0, seq_err = 0, stab_err = 0, exp_idx = 0;
  int cs_err = 0;
  logic cs_seen = 1'b0;

  assign held_now = ({x, y} != prev_xy) ? 1 : held + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      held     <= 0;
      prev_xy  <= '0;
      samp_cnt <= 0;
      fb_cnt   <= 0;
      fb_err   <= 0;
      seq_err  <= 0;
      stab_err <= 0;
      exp_idx  <= 0;
      wrap_xy  <= '1;
      cs_seen  <= 1'b0;
    end else begin
      held    <= held_now;
      prev_xy <= {x, y};
      if (!cs) cs_seen <= 1'b1;
      else if (cs_seen) cs_err <= cs_err + 1;
      if (sample_pixel) begin
        samp_cnt <= samp_cnt + 1;
        if (held_now < HOLD) stab_err <= stab_err + 1;
        if (int'(pixel_index) != exp_idx || int'(pixel_index) != int'(y) * 96 + int'(x))
          seq_err <= seq_err + 1;
        if (frame_begin != (pixel_index == 13'd0)) fb_err <= fb_err + 1;
        if (frame_begin) begin
          fb_cnt <= fb_cnt + 1;
          if (samp_cnt != 0) wrap_xy <= last_xy;
        end
        last_xy <= {x, y};
        exp_idx <= (exp_idx == NPIX - 1) ? 0 : exp_idx + 1;
      end else if (frame_begin) begin
        fb_err <= fb_err + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [9:0] ctrl_vec();
    return {cs, sclk, sdin, d_cn, resn, vccen, pmoden, ready, sample_pixel, frame_begin};
  endfunction

  localparam logic [9:0] CTRL_RST = 10'b11_0000_0000;

  initial begin
    int n;
    int base;

    // Reset hold
    repeat (3) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_ctrl", ctrl_vec(), CTRL_RST);
    end
    check("reset_coords", {pixel_index, x, y}, 0);

    // Release and power-up
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("pmoden_after_release", pmoden, 1);
    n = 0;
    while (!resn && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("resn_low_cycles", n, 20);

    // Init command stream
    n = 0;
    while (!vccen && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("vccen_rise_timeout", vccen, 1);
    check("init_byte_count", cmd_q.size(), 37);
    check("init_byte0", cmd_q[0], 8'hAE);
    check("init_byte1", cmd_q[1], 8'hA0);
    check("init_byte2", cmd_q[2], 8'h72);
    check("init_byte36", cmd_q[36], 8'h2E);
    check("cs_low_init", cs, 0);

    // Display on
    n = 0;
    while (sclk && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("af_start_delay", n, 21);
    check("af_dcn", d_cn, 0);
    n = 0;
    while (!ready && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_rise_timeout", ready, 1);
    check("ready_sclk_fall", sclk, 0);
    check("ready_dcn", d_cn, 1);
    check("cmd_count_af", cmd_q.size(), 38);
    check("af_byte", cmd_q[37], 8'hAF);

    // Pixel stream through one frame wrap
    n = 0;
    while (samp_cnt < NPIX + 4 && n < 40000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pixel_stream_timeout", samp_cnt >= NPIX + 4, 1);
    check("pix_word_count", pix_q.size() >= NPIX + 1, 1);
    check("pix_word0", pix_q[0], 16'h0000);
    check("pix_word1", pix_q[1], 16'h0200);
    check("pix_word96", pix_q[96], 16'h0001);
    check("pix_word383", pix_q[383], 16'hBE03);
    check("pix_word384", pix_q[384], 16'h0000);
    check("frame_begin_count", fb_cnt, 2);
    check("frame_begin_err", fb_err, 0);
    check("index_seq_err", seq_err, 0);
    check("xy_stable_err", stab_err, 0);
    check("wrap_prev_xy", wrap_xy, {7'd95, 7'd3});
    check("cs_rose_err", cs_err, 0);
    check("ready_held", ready, 1);

    // Asynchronous reset during pixel 5 (second frame), 9th bit
    n = 0;
    while (!(pix_q.size() == NPIX + 5 && bitcnt == 8) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pix5_bit8_timeout", pix_q.size() == NPIX + 5 && bitcnt == 8, 1);
    n = 0;
    while (sclk && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pix5_bit9_started", sclk, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_ctrl", ctrl_vec(), CTRL_RST);
    check("async_reset_coords", {pixel_index, x, y}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_sclk_static", {sclk, cs}, 2'b11);
    end

    // Replay from the top of the init stream
    base = cmd_q.size();
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (cmd_q.size() < base + 2 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("replay_timeout", cmd_q.size() >= base + 2, 1);
    check("replay_byte0", cmd_q[base], 8'hAE);
    check("replay_byte1", cmd_q[base+1], 8'hA0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
